// File: rtl/dma_sequencer_if.sv
// Bus bundle for dma_sequencer: external source fetch handshake plus
// destination memory-map write port.
interface dma_sequencer_if;
  logic [31:0] ext_addr;
  logic        ext_req;
  logic        ext_ack;
  logic [15:0] ext_data;
  logic        bus_req;
  logic        bus_grant;
  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_write;

  modport master (
    output ext_addr, ext_req,
    input  ext_ack, ext_data,
    output bus_req, bus_addr, bus_wdata, bus_write,
    input  bus_grant
  );

  modport slave (
    input  ext_addr, ext_req,
    output ext_ack, ext_data,
    input  bus_req, bus_addr, bus_wdata, bus_write,
    output bus_grant
  );
endinterface

// File: rtl/dma_sequencer.sv
// Register-programmed DMA copying 16-bit words from a 32-bit external source
// into the 16-bit memory map, one word per fetch/write pair.
module dma_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dma_en,
  input  logic [1:0]             dma_mode,
  input  logic                   memwrite,
  input  logic [15:0]            writedata,
  output logic [15:0]            dma_rdata,
  dma_sequencer_if.master        bus,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {IDLE, REQ, FETCH, WRITE, DONE} state_t;

  state_t             state_q, state_d;
  logic [31:0]        src;
  logic [15:0]        dst;
  logic [CNT_W-1:0]   cnt;
  logic [15:0]        latch;
  logic [CNT_W-1:0]   amt_wr;
  logic               cpu_wr;
  logic               start;
  logic               write_fire;

  // Register writes are only honoured while idle, so a running copy cannot be retargeted.
  assign cpu_wr     = dma_en & memwrite & (state_q == IDLE);
  assign amt_wr     = CNT_W'(writedata);
  assign start      = cpu_wr && (dma_mode == 2'd3) && (amt_wr != '0);
  assign write_fire = (state_q == WRITE) && bus.bus_grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    busy          = 1'b0;
    done          = 1'b0;
    bus.bus_req   = 1'b0;
    bus.ext_req   = 1'b0;
    bus.bus_write = 1'b0;
    bus.ext_addr  = src;
    bus.bus_addr  = dst;
    bus.bus_wdata = latch;
    case (state_q)
      IDLE: begin
        if (start) state_d = REQ;
      end
      REQ: begin
        busy        = 1'b1;
        bus.bus_req = 1'b1;
        if (bus.bus_grant) state_d = FETCH;
      end
      FETCH: begin
        busy        = 1'b1;
        bus.bus_req = 1'b1;
        bus.ext_req = 1'b1;
        if (bus.ext_ack) state_d = WRITE;
      end
      WRITE: begin
        busy          = 1'b1;
        bus.bus_req   = 1'b1;
        bus.bus_write = bus.bus_grant;
        // cnt still holds the pre-decrement value here, so 1 means last word.
        if (bus.bus_grant) state_d = (cnt == CNT_W'(1)) ? DONE : FETCH;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src   <= '0;
      dst   <= '0;
      cnt   <= '0;
      latch <= '0;
    end else begin
      if (cpu_wr) begin
        case (dma_mode)
          2'd0: src[15:0]  <= writedata;
          2'd1: src[31:16] <= writedata;
          2'd2: dst        <= writedata;
          default: cnt     <= amt_wr;
        endcase
      end
      if ((state_q == FETCH) && bus.ext_ack) latch <= bus.ext_data;
      if (write_fire) begin
        src <= src + 32'd1;
        dst <= dst + 16'd1;
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    case (dma_mode)
      2'd0:    dma_rdata = src[15:0];
      2'd1:    dma_rdata = src[31:16];
      2'd2:    dma_rdata = dst;
      default: dma_rdata = 16'(cnt);
    endcase
  end

endmodule
